// File: rtl/scarv_cop_pkg.sv
// Shared definitions for the CPU-side coprocessor instruction issue path:
// COP result codes and the issue FSM state encoding.
package scarv_cop_pkg;

  localparam logic [2:0] RES_SUCCESS = 3'd0;
  localparam logic [2:0] RES_ABORT   = 3'd1;
  localparam logic [2:0] RES_BAD_INS = 3'd2;
  localparam logic [2:0] RES_TIMEOUT = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/scarv_cop_issue_if.sv
// Bundle of the pipeline issue channel, COP req/ack/rsp handshake and the
// response channel back to the pipeline. master = issue block, slave = its environment.
interface scarv_cop_issue_if;

  logic        iss_valid;
  logic        iss_ready;
  logic [31:0] iss_encoded;
  logic [31:0] iss_rs1;
  logic        iss_flush;

  logic        cpu_insn_req;
  logic        cop_insn_ack;
  logic [31:0] cpu_insn_enc;
  logic [31:0] cpu_rs1;
  logic        cop_insn_rsp;
  logic        cpu_insn_ack;
  logic        cop_wen;
  logic [4:0]  cop_waddr;
  logic [31:0] cop_wdata;
  logic [2:0]  cop_result;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_wen;
  logic [4:0]  rsp_waddr;
  logic [31:0] rsp_wdata;
  logic [2:0]  rsp_result;

  modport master (
    input  iss_valid, iss_encoded, iss_rs1, iss_flush,
    output iss_ready,
    output cpu_insn_req, cpu_insn_enc, cpu_rs1, cpu_insn_ack,
    input  cop_insn_ack, cop_insn_rsp, cop_wen, cop_waddr, cop_wdata, cop_result,
    output rsp_valid, rsp_wen, rsp_waddr, rsp_wdata, rsp_result,
    input  rsp_ready
  );

  modport slave (
    output iss_valid, iss_encoded, iss_rs1, iss_flush,
    input  iss_ready,
    input  cpu_insn_req, cpu_insn_enc, cpu_rs1, cpu_insn_ack,
    output cop_insn_ack, cop_insn_rsp, cop_wen, cop_waddr, cop_wdata, cop_result,
    input  rsp_valid, rsp_wen, rsp_waddr, rsp_wdata, rsp_result,
    output rsp_ready
  );

endinterface

// File: rtl/scarv_cop_issue_rspreg.sv
// Response holding register: captures the COP writeback or substitutes a timeout
// result, then presents it on a valid/ready channel until the pipeline takes it.
module scarv_cop_issue_rspreg
  import scarv_cop_pkg::*;
(
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        cap_rsp,
  input  logic        cap_tmo,
  input  logic        cop_wen,
  input  logic [4:0]  cop_waddr,
  input  logic [31:0] cop_wdata,
  input  logic [2:0]  cop_result,
  input  logic        rsp_ready,
  output logic        rsp_valid,
  output logic        rsp_wen,
  output logic [4:0]  rsp_waddr,
  output logic [31:0] rsp_wdata,
  output logic [2:0]  rsp_result
);

  // A timeout carries no writeback, so the GPR fields are forced to zero.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      rsp_valid  <= 1'b0;
      rsp_wen    <= 1'b0;
      rsp_waddr  <= '0;
      rsp_wdata  <= '0;
      rsp_result <= RES_SUCCESS;
    end else if (cap_rsp || cap_tmo) begin
      rsp_valid  <= 1'b1;
      rsp_wen    <= cap_rsp & cop_wen;
      rsp_waddr  <= cap_rsp ? cop_waddr : 5'd0;
      rsp_wdata  <= cap_rsp ? cop_wdata : 32'd0;
      rsp_result <= cap_rsp ? cop_result : RES_TIMEOUT;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/scarv_cop_issue.sv
// CPU-side initiator for the coprocessor instruction interface: issues one
// instruction at a time over req/ack and returns the COP response to the pipeline.
module scarv_cop_issue
  import scarv_cop_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TCNT_W         = 8
) (
  input  logic              g_clk,
  input  logic              g_reset,
  scarv_cop_issue_if.master bus
);

  localparam logic [TCNT_W-1:0] TMO_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [TCNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]       enc_q, rs1_q;
  logic              ack_q;
  logic              accept, cap_rsp, cap_tmo, tmo_hit;
  logic              rsp_valid;

  function automatic logic [TCNT_W-1:0] sat_inc(input logic [TCNT_W-1:0] v);
    return (v == {TCNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // The timeout fires on the WAIT cycle whose increment would reach TIMEOUT_CYCLES.
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TMO_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    cap_rsp = 1'b0;
    cap_tmo = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.iss_valid && !bus.iss_flush) begin
          accept  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.cop_insn_ack) begin
          cnt_d = '0;
          if (bus.cop_insn_rsp) begin
            cap_rsp = 1'b1;
            state_d = HOLD;
          end else begin
            state_d = WAIT;
          end
        end else if (bus.iss_flush) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = sat_inc(cnt_q);
        if (bus.cop_insn_rsp) begin
          cap_rsp = 1'b1;
          state_d = HOLD;
        end else if (tmo_hit) begin
          cap_tmo = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (rsp_valid && bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      enc_q   <= '0;
      rs1_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= cap_rsp;
      if (accept) begin
        enc_q <= bus.iss_encoded;
        rs1_q <= bus.iss_rs1;
      end
    end
  end

  // Ready is masked while reset is held so every output reads 0 during reset.
  assign bus.iss_ready    = (state_q == IDLE) && !g_reset;
  assign bus.cpu_insn_req = (state_q == REQ);
  assign bus.cpu_insn_enc = enc_q;
  assign bus.cpu_rs1      = rs1_q;
  assign bus.cpu_insn_ack = ack_q;
  assign bus.rsp_valid    = rsp_valid;

  scarv_cop_issue_rspreg u_rspreg (
    .g_clk      (g_clk),
    .g_reset    (g_reset),
    .cap_rsp    (cap_rsp),
    .cap_tmo    (cap_tmo),
    .cop_wen    (bus.cop_wen),
    .cop_waddr  (bus.cop_waddr),
    .cop_wdata  (bus.cop_wdata),
    .cop_result (bus.cop_result),
    .rsp_ready  (bus.rsp_ready),
    .rsp_valid  (rsp_valid),
    .rsp_wen    (bus.rsp_wen),
    .rsp_waddr  (bus.rsp_waddr),
    .rsp_wdata  (bus.rsp_wdata),
    .rsp_result (bus.rsp_result)
  );

  a_req_hold: assert property (@(posedge g_clk) disable iff (g_reset)
    (bus.cpu_insn_req && !bus.cop_insn_ack && !bus.iss_flush) |=> bus.cpu_insn_req);

  a_rsp_stable: assert property (@(posedge g_clk) disable iff (g_reset)
    (rsp_valid && !bus.rsp_ready) |=>
      (rsp_valid && $stable({bus.rsp_wen, bus.rsp_waddr, bus.rsp_wdata, bus.rsp_result})));

  a_ack_single: assert property (@(posedge g_clk) disable iff (g_reset)
    bus.cpu_insn_ack |=> !bus.cpu_insn_ack);

  a_ack_with_rsp: assert property (@(posedge g_clk) disable iff (g_reset)
    bus.cpu_insn_ack |-> rsp_valid);

endmodule

// File: doc/scarv_cop_issue.md
Name: scarv_cop_issue

Overview:
- CPU-side initiator for the coprocessor instruction interface; the opposite end of the instruction decoder.
- Accepts one 32-bit ISE instruction and its rs1 operand from the host pipeline, then drives the req/ack handshake into the COP.
- Captures the COP response (GPR writeback plus result code) and returns it to the pipeline over a valid/ready channel.
- Supports one instruction in flight, a response timeout, and a pre-acknowledge flush.

Parameters:
- TIMEOUT_CYCLES, 255, cycles to wait after ack for cop_insn_rsp before reporting a timeout (>=1; 0 disables the timeout).
- TCNT_W, 8, width of the timeout counter; must satisfy 2**TCNT_W > TIMEOUT_CYCLES.

Ports:
- g_clk  in  1  single clock; all logic on the rising edge.
- g_reset  in  1  synchronous, active-high reset.
- iss_valid  in  1  pipeline presents an ISE instruction.
- iss_ready  out  1  block can accept (state IDLE).
- iss_encoded  in  32  encoded instruction.
- iss_rs1  in  32  GPR rs1 value.
- iss_flush  in  1  pipeline kill request.
- cpu_insn_req  out  1  instruction request to the COP.
- cop_insn_ack  in  1  COP accepted the request.
- cpu_insn_enc  out  32  registered copy of iss_encoded.
- cpu_rs1  out  32  registered copy of iss_rs1.
- cop_insn_rsp  in  1  COP response valid.
- cpu_insn_ack  out  1  response consumed (one-cycle pulse).
- cop_wen  in  1  GPR write requested.
- cop_waddr  in  5  GPR address.
- cop_wdata  in  32  GPR data.
- cop_result  in  3  COP result code.
- rsp_valid  out  1  response to the pipeline.
- rsp_ready  in  1  pipeline accepts the response.
- rsp_wen  out  1  registered cop_wen.
- rsp_waddr  out  5  registered cop_waddr.
- rsp_wdata  out  32  registered cop_wdata.
- rsp_result  out  3  registered result, or RES_TIMEOUT.

Behaviour:
- Reset values: all outputs 0, state IDLE, counter 0.
  - A reset in any state returns to IDLE on the next edge with no pulses.
  - A COP transaction abandoned by reset is the system's responsibility; the COP is reset from the same source.
- State IDLE:
  - iss_ready=1.
  - iss_valid & ~iss_flush: register the encoding and rs1, then go to REQ. cpu_insn_req rises one cycle after acceptance.
  - iss_valid & iss_flush in the same cycle: drop the instruction and stay in IDLE.
- State REQ:
  - cpu_insn_req=1; cpu_insn_enc and cpu_rs1 stay stable until ack.
  - cop_insn_ack: drop req next cycle, clear the counter, go to WAIT.
  - ack & cop_insn_rsp in the same cycle: capture the response immediately, pulse cpu_insn_ack, go to HOLD.
  - iss_flush without ack: drop req and go to IDLE; no response is produced.
  - Flush in the same cycle as ack: the ack wins and flush is ignored.
- State WAIT:
  - iss_flush is ignored, because the COP has committed.
  - cop_insn_rsp: register wen/waddr/wdata/result, pulse cpu_insn_ack for exactly one cycle (the next cycle), go to HOLD.
  - The counter increments each WAIT cycle. When it reaches TIMEOUT_CYCLES without a response:
    - load rsp_result=RES_TIMEOUT and rsp_wen=0;
    - go to HOLD with no cpu_insn_ack;
    - ignore any later cop_insn_rsp until the next transaction (it is not acked).
  - A response arriving on the exact timeout cycle takes priority over the timeout.
- State HOLD:
  - rsp_valid=1 with payload stable.
  - rsp_valid & rsp_ready: go to IDLE next cycle.
  - iss_ready stays 0 in HOLD, so back-to-back issue costs at least one IDLE cycle.
- Latency, zero-wait COP (ack on the first req cycle, rsp the cycle after): acceptance at T0, req at T1, rsp at T2, rsp_valid at T3.
- Width rules:
  - The counter saturates and never wraps.
  - The result code passes through unmodified except for the timeout substitution.
- Assertions:
  - cpu_insn_req never falls without ack or flush.
  - Payload is stable while rsp_valid & ~rsp_ready.
  - At most one cpu_insn_ack pulse per transaction.

Decomposition:
- Shared package scarv_cop_pkg (or the common include) holds:
  - result codes RES_SUCCESS=3'd0, RES_ABORT=3'd1, RES_BAD_INS=3'd2, RES_TIMEOUT=3'd7;
  - the 2-bit state encoding IDLE/REQ/WAIT/HOLD.
- One natural sub-module: scarv_cop_issue_rspreg, the HOLD-state response register with valid/ready and the timeout substitution mux.
- The FSM and counter stay in the top module.

Test Plan:
- Basic issue: iss_encoded=32'h0C21_002B, rs1=32'hDEAD_BEEF; COP acks after 2 cycles and responds 3 cycles later with wen=1, waddr=5, wdata=32'h1234_5678, result=0 -> one req episode, one cpu_insn_ack pulse, rsp payload matches, rsp_valid held until rsp_ready.
- Ack and rsp in the same cycle -> cpu_insn_ack pulses once, HOLD entered, no extra req cycles.
- Flush in REQ before ack -> req drops next cycle, no rsp_valid, iss_ready back at 1; flush in WAIT -> ignored, response still delivered.
- Timeout: TIMEOUT_CYCLES=4, COP acks but never responds -> rsp_result=3'd7 and rsp_wen=0 after exactly 4 WAIT cycles; a late rsp is not acked.
- Backpressure: hold rsp_ready=0 for 10 cycles -> payload stable, iss_ready=0, then a single handoff.
- Reset asserted in WAIT -> all outputs 0 next cycle; a fresh issue afterwards completes normally.
